// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the frame width helper.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t LOADED   = 2'd1;
  localparam state_t SENDING  = 2'd2;
  localparam state_t FINISHED = 2'd3;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_width(input int data_w, input bit parity);
    return data_w + (parity ? 3 : 2);
  endfunction

endpackage

// File: rtl/uart_tx_fd_if.sv
// Control/status bundle between the tx_uc control unit (master) and the uart_tx_fd datapath (slave).
interface uart_tx_fd_if #(
  parameter int DATA_W = 8
);
  logic              reset_fd;
  logic              load;
  logic              shift_en;
  logic [DATA_W-1:0] data_in;
  logic              tx_serial;
  logic              stop_bit_done;
  logic              busy;

  modport master (
    output reset_fd, load, shift_en, data_in,
    input  tx_serial, stop_bit_done, busy
  );

  modport slave (
    input  reset_fd, load, shift_en, data_in,
    output tx_serial, stop_bit_done, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tick on the terminal count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & ~clear & (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_fd.sv
// UART transmit datapath: serialises start, DATA_W data bits LSB-first, optional parity and stop.
// Even parity is inserted when UART_TX_PARITY_EN is defined.
//
//  state    | meaning
//  IDLE     | nothing loaded, line idle
//  LOADED   | frame captured, waiting for shift_en
//  SENDING  | frame bits on the line
//  FINISHED | stop bit elapsed, waiting for next load
module uart_tx_fd
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input logic         clk,
  input logic         rst,
  uart_tx_fd_if.slave bus
);
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FRAME_W = frame_width(DATA_W, PARITY_EN);
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  state_t             state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_init;
  logic [BIT_W-1:0]   bit_cnt;
  logic               stop_done;
  logic               tick;
  logic               baud_clear;
  logic               baud_en;

  always_comb begin
`ifdef UART_TX_PARITY_EN
    frame_init = {STOP_BIT, ^bus.data_in, bus.data_in, START_BIT};
`else
    frame_init = {STOP_BIT, bus.data_in, START_BIT};
`endif
  end

  assign baud_clear = bus.reset_fd | bus.load;
  assign baud_en    = (state == SENDING) & bus.shift_en;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .en   (baud_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      stop_done <= 1'b0;
    end else begin
      stop_done <= 1'b0;
      if (bus.reset_fd) begin
        state   <= IDLE;
        frame   <= '0;
        bit_cnt <= '0;
      end else if (bus.load) begin
        state   <= LOADED;
        frame   <= frame_init;
        bit_cnt <= '0;
      end else begin
        case (state)
          LOADED: begin
            if (bus.shift_en) state <= SENDING;
          end
          SENDING: begin
            if (tick) begin
              frame   <= {STOP_BIT, frame[FRAME_W-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              // bit_cnt parks at FRAME_W; FINISHED never ticks so it cannot wrap
              if (bit_cnt == LAST_BIT) begin
                state     <= FINISHED;
                stop_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_serial     = (state == SENDING) ? frame[0] : LINE_IDLE;
  assign bus.busy          = (state == LOADED) || (state == SENDING);
  assign bus.stop_bit_done = stop_done;
endmodule

// File: tb/tb_uart_tx_fd.sv
// Scoreboard bench for uart_tx_fd: per-cycle expected line/status values are queued as stimulus is driven.
module tb_uart_tx_fd;
  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FW = DW + 3;
`else
  localparam int FW = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fd_if #(.DATA_W(DW)) bus ();

  uart_tx_fd #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int   due;
    logic tx;
    logic done;
    logic busy;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          n_pulse = 0;
  int          pulse_cyc = 0;
  int          m_st = 0;
  int          m_pos = 0;
  int          t_send = 0;
  logic [15:0] m_bits = '1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [7:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[DW+1] = ^d;
`endif
    return f;
  endfunction

  // Model tracks enabled SENDING cycles; line shows frame bit pos/CPB.
  task automatic cyc(input logic ld, input logic sh, input logic rfd, input logic [7:0] d);
    exp_t e;
    bus.load     = ld;
    bus.shift_en = sh;
    bus.reset_fd = rfd;
    bus.data_in  = d;
    e.done = 1'b0;
    if (rfd) m_st = 0;
    else if (ld) begin
      m_st = 1; m_bits = mk_frame(d); m_pos = 0;
    end else if (m_st == 1 && sh) begin
      m_st = 2; m_pos = 0; t_send = cyc_cnt + 1;
    end else if (m_st == 2 && sh) begin
      m_pos++;
      if (m_pos == FW * CPB) begin
        m_st = 3; e.done = 1'b1;
      end
    end
    e.due  = cyc_cnt + 1;
    e.tx   = (m_st == 2) ? m_bits[m_pos / CPB] : 1'b1;
    e.busy = (m_st == 1 || m_st == 2);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.stop_bit_done === 1'b1) begin
      n_pulse++;
      pulse_cyc = cyc_cnt;
    end
    while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
      e = sb.pop_front();
      chk("tx_serial", bus.tx_serial, e.tx);
      chk("stop_bit_done", bus.stop_bit_done, e.done);
      chk("busy", bus.busy, e.busy);
    end
  end

  task automatic send_frame(input logic [7:0] d, input int pause_pos, input int pause_len,
                            input int abort_pos);
    int p0, paused, guard;
    bit aborted;
    p0 = n_pulse; paused = 0; guard = 0; aborted = 0;
    cyc(1'b1, 1'b0, 1'b0, d);
    while (m_st != 3 && !aborted && guard < 300) begin
      guard++;
      if (m_st == 2 && m_pos == abort_pos) begin
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        aborted = 1;
      end else if (m_st == 2 && m_pos == pause_pos && paused < pause_len) begin
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        paused++;
      end else begin
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
      end
    end
    chk("frame_bound", guard < 300, 1);
    // shift_en must be ignored once FINISHED (or IDLE after abort)
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    if (aborted) chk("no_pulse_after_abort", n_pulse - p0, 0);
    else begin
      chk("pulse_count", n_pulse - p0, 1);
      chk("pulse_latency", pulse_cyc - t_send, FW * CPB + pause_len);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 1'b0; bus.shift_en = 1'b0; bus.reset_fd = 1'b0; bus.data_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_tx_serial", bus.tx_serial, 1);
    chk("rst_stop_bit_done", bus.stop_bit_done, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 8'h00);

    send_frame(8'hA5, -1, 0, -1);
    send_frame(8'hA5, 4 * CPB + 1, 5, -1);
    send_frame(8'hA5, -1, 0, 6 * CPB + 1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h3C, -1, 0, -1);
    send_frame(8'h01, -1, 0, -1);

    cyc(1'b1, 1'b0, 1'b0, 8'h12);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h55);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00);

    cyc(1'b1, 1'b0, 1'b0, 8'hC3);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx_serial", bus.tx_serial, 1);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_stop_bit_done", bus.stop_bit_done, 0);
    sb.delete();
    m_st = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    send_frame(8'hFF, -1, 0, -1);

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
